// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle for seg7_scan_ctrl: value/strobe inputs from the
// system side and decoder/digit-driver outputs from the scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              dig_code;
  logic                    dec_blank;
  logic [NUM_DIGITS-1:0]   dig_sel_n;
  logic                    dp_n;
  logic [IDX_W-1:0]        scan_idx;
  logic                    frame_tick;
  logic                    upd_done;

  // System side: supplies display data, observes the scan outputs.
  modport master (
    output en, load, value, dp_in, blank_mask,
    input  dig_code, dec_blank, dig_sel_n, dp_n, scan_idx, frame_tick, upd_done
  );

  // Scan controller side.
  modport slave (
    input  en, load, value, dp_in, blank_mask,
    output dig_code, dec_blank, dig_sel_n, dp_n, scan_idx, frame_tick, upd_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Double-buffered value (shadow -> active at frame boundary), per-slot
// blanking guard, active-low digit selects, all outputs registered.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seg7_scan_ctrl_if.slave        bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] D_LAST   = CNT_W'(REFRESH_DIV - GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  boundary;

  logic [DW-1:0]         shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0] shd_dp_q, shd_dp_d;
  logic [DW-1:0]         act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic                  pend_q, pend_d;

  logic [3:0]            code_q, code_d;
  logic                  dblank_q, dblank_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  dpn_q, dpn_d;
  logic                  ft_q, ft_d;
  logic                  ud_q, ud_d;

  logic [NUM_DIGITS-1:0] lz;
  logic [3:0]            nib;
  logic                  cur_dp;
  logic                  cur_blk;

  // Scan sequencer: slot counter, digit index and frame-boundary detect.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!bus.en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_GUARD;
          cnt_d   = '0;
          idx_d   = '0;
        end
        S_GUARD: begin
          if (cnt_q == G_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end
        end
        S_DRIVE: begin
          if (cnt_q == D_LAST) begin
            state_d = S_GUARD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Shadow capture on load; shadow -> active at the frame boundary.
  // A load on the boundary edge still transfers the old shadow and re-arms pending.
  always_comb begin
    shd_val_d = shd_val_q;
    shd_dp_d  = shd_dp_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    pend_d    = pend_q;
    if (boundary && pend_q) begin
      act_val_d = shd_val_q;
      act_dp_d  = shd_dp_q;
      pend_d    = 1'b0;
    end
    if (bus.load) begin
      shd_val_d = bus.value;
      shd_dp_d  = bus.dp_in;
      pend_d    = 1'b1;
    end
  end

`ifdef SEG7_LZB_EN
  logic allz;

  // Leading-zero flags from the active buffer, scanning from the MSD down.
  always_comb begin
    lz   = '0;
    allz = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      allz = allz & (act_val_d[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      if (NUM_DIGITS - 1 - k != 0) lz[NUM_DIGITS-1-k] = allz;
    end
  end
`else
  assign lz = '0;
`endif

  // Select nibble, decimal point and blank condition for the upcoming digit.
  always_comb begin
    nib     = '0;
    cur_dp  = 1'b0;
    cur_blk = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib     = act_val_d[4*k +: 4];
        cur_dp  = act_dp_d[k];
        cur_blk = bus.blank_mask[k] | lz[k];
      end
    end
  end

  // Output values for the state being entered, so pins track the state register.
  always_comb begin
    code_d   = '0;
    dblank_d = 1'b1;
    sel_d    = '1;
    dpn_d    = 1'b1;
    ft_d     = boundary;
    ud_d     = boundary & pend_q;
    case (state_d)
      S_GUARD: code_d = nib;
      S_DRIVE: begin
        code_d       = nib;
        sel_d[idx_d] = 1'b0;
        dblank_d     = cur_blk;
        dpn_d        = cur_blk | ~cur_dp;
      end
      default: ;
    endcase
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shd_val_q <= '0;
      shd_dp_q  <= '0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      pend_q    <= 1'b0;
      code_q    <= '0;
      dblank_q  <= 1'b1;
      sel_q     <= '1;
      dpn_q     <= 1'b1;
      ft_q      <= 1'b0;
      ud_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shd_val_q <= shd_val_d;
      shd_dp_q  <= shd_dp_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      pend_q    <= pend_d;
      code_q    <= code_d;
      dblank_q  <= dblank_d;
      sel_q     <= sel_d;
      dpn_q     <= dpn_d;
      ft_q      <= ft_d;
      ud_q      <= ud_d;
    end
  end

  assign bus.dig_code   = code_q;
  assign bus.dec_blank  = dblank_q;
  assign bus.dig_sel_n  = sel_q;
  assign bus.dp_n       = dpn_q;
  assign bus.scan_idx   = idx_q;
  assign bus.frame_tick = ft_q;
  assign bus.upd_done   = ud_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2).
module tb_seg7_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
`ifdef SEG7_LZB_EN
  localparam logic LZB = 1'b1;
`else
  localparam logic LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .GUARD_CYC  (GC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  mask;
    int          digit;
    logic [3:0]  code;
    logic        blank;
    logic        dpn;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ft(input int maxc, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (n < maxc) begin
      step();
      n++;
      if (bus.frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Walks one full frame starting from a boundary sample, with optional loads.
  task automatic check_frame(input logic [15:0] v, input int c1, input logic [15:0] v1,
                             input int c2, input logic [15:0] v2,
                             input logic exp_ud, input logic [3:0] exp_bcode);
    int s, p;
    logic [3:0] esel;
    for (int c = 1; c <= ND * RD; c++) begin
      if (c == c1) begin
        bus.value = v1; bus.load = 1'b1;
      end else if (c == c2) begin
        bus.value = v2; bus.load = 1'b1;
      end
      step();
      bus.load = 1'b0;
      if (c < ND * RD) begin
        s = c / RD;
        p = c % RD;
        esel = 4'hF;
        if (p >= GC) esel[s] = 1'b0;
        chk("frm_sel",   32'(bus.dig_sel_n),  32'(esel));
        chk("frm_code",  32'(bus.dig_code),   32'((v >> (4 * s)) & 16'hF));
        chk("frm_blank", 32'(bus.dec_blank),  32'(p < GC));
        chk("frm_idx",   32'(bus.scan_idx),   32'(s));
        chk("frm_dpn",   32'(bus.dp_n),       32'(1));
        chk("frm_ft",    32'(bus.frame_tick), 32'(0));
        chk("frm_ud",    32'(bus.upd_done),   32'(0));
      end else begin
        chk("bnd_ft",   32'(bus.frame_tick), 32'(1));
        chk("bnd_ud",   32'(bus.upd_done),   32'(exp_ud));
        chk("bnd_idx",  32'(bus.scan_idx),   32'(0));
        chk("bnd_sel",  32'(bus.dig_sel_n),  32'(4'hF));
        chk("bnd_code", 32'(bus.dig_code),   32'(exp_bcode));
      end
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_sel"},   32'(bus.dig_sel_n),  32'(4'hF));
    chk({pfx, "_code"},  32'(bus.dig_code),   32'(0));
    chk({pfx, "_blank"}, 32'(bus.dec_blank),  32'(1));
    chk({pfx, "_dpn"},   32'(bus.dp_n),       32'(1));
    chk({pfx, "_idx"},   32'(bus.scan_idx),   32'(0));
    chk({pfx, "_ft"},    32'(bus.frame_tick), 32'(0));
    chk({pfx, "_ud"},    32'(bus.upd_done),   32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic ok;
    logic [3:0] esel;

    vecs[0] = '{16'h0050, 4'b0010, 4'b0000, 1, 4'h5, 1'b0, 1'b0};
    vecs[1] = '{16'h0050, 4'b0010, 4'b0000, 3, 4'h0, LZB,  1'b1};
    vecs[2] = '{16'h0050, 4'b0010, 4'b0000, 2, 4'h0, LZB,  1'b1};
    vecs[3] = '{16'h0050, 4'b0010, 4'b0000, 0, 4'h0, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 4'b0100, 4'b0100, 2, 4'h2, 1'b1, 1'b1};
    vecs[5] = '{16'h1234, 4'b0100, 4'b0100, 3, 4'h1, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 4'b0001, 4'b0000, 0, 4'h0, 1'b0, 1'b0};
    vecs[7] = '{16'hF0F0, 4'b0000, 4'b0000, 2, 4'h0, 1'b0, 1'b1};
    vecs[8] = '{16'h0007, 4'b0000, 4'b0000, 1, 4'h0, LZB,  1'b1};
    vecs[9] = '{16'h0007, 4'b0001, 4'b0000, 0, 4'h7, 1'b0, 1'b0};

    bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_mask = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    // Power-up: load 1234 while idle, then enable.
    bus.value = 16'h1234; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.en = 1'b1;
    step();
    chk("a0_sel", 32'(bus.dig_sel_n), 32'(4'hF));
    chk("a0_idx", 32'(bus.scan_idx), 32'(0));
    chk("a0_blank", 32'(bus.dec_blank), 32'(1));
    step();
    chk("a1_sel", 32'(bus.dig_sel_n), 32'(4'hF));
    step();
    chk("a2_sel", 32'(bus.dig_sel_n), 32'(4'hE));
    chk("a2_code", 32'(bus.dig_code), 32'(0));
    chk("a2_blank", 32'(bus.dec_blank), 32'(0));
    wait_ft(40, n, ok);
    chk("first_bnd_seen", 32'(ok), 32'(1));
    chk("first_bnd_cyc", 32'(n), 32'(30));
    chk("first_bnd_ud", 32'(bus.upd_done), 32'(1));
    chk("first_bnd_code", 32'(bus.dig_code), 32'(4'h4));

    // Free run, mid-frame load, and load coinciding with the boundary.
    check_frame(16'h1234, 0, 16'h0, 0, 16'h0, 1'b0, 4'h4);
    check_frame(16'h1234, 10, 16'hABCD, 0, 16'h0, 1'b1, 4'hD);
    check_frame(16'hABCD, 0, 16'h0, 0, 16'h0, 1'b0, 4'hD);
    check_frame(16'hABCD, 10, 16'h5678, ND * RD, 16'h9EF0, 1'b1, 4'h8);
    check_frame(16'h5678, 0, 16'h0, 0, 16'h0, 1'b1, 4'h0);
    check_frame(16'h9EF0, 0, 16'h0, 0, 16'h0, 1'b0, 4'h0);

    // Drop en during DRIVE of digit 2, then restart.
    repeat (20) step();
    chk("drv2_sel", 32'(bus.dig_sel_n), 32'(4'hB));
    chk("drv2_idx", 32'(bus.scan_idx), 32'(2));
    bus.en = 1'b0;
    step();
    chk("off_sel", 32'(bus.dig_sel_n), 32'(4'hF));
    chk("off_blank", 32'(bus.dec_blank), 32'(1));
    chk("off_idx", 32'(bus.scan_idx), 32'(0));
    repeat (3) step();
    chk("idle_sel", 32'(bus.dig_sel_n), 32'(4'hF));
    bus.en = 1'b1;
    step();
    chk("re_a0_sel", 32'(bus.dig_sel_n), 32'(4'hF));
    chk("re_a0_idx", 32'(bus.scan_idx), 32'(0));
    step();
    step();
    chk("re_a2_sel", 32'(bus.dig_sel_n), 32'(4'hE));
    chk("re_a2_code", 32'(bus.dig_code), 32'(4'h0));
    repeat (8) step();
    chk("re_a10_sel", 32'(bus.dig_sel_n), 32'(4'hD));
    chk("re_a10_code", 32'(bus.dig_code), 32'(4'hF));
    chk("re_a10_idx", 32'(bus.scan_idx), 32'(1));

    // Per-digit decode/blank/dp vectors.
    for (int i = 0; i < 10; i++) begin
      bus.value = vecs[i].value;
      bus.dp_in = vecs[i].dp;
      bus.blank_mask = vecs[i].mask;
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 80; k++) begin
        step();
        if (bus.upd_done === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      chk($sformatf("tbl%0d_upd", i), 32'(ok), 32'(1));
      esel = 4'hF;
      esel[vecs[i].digit] = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        step();
        if (bus.dig_sel_n === esel) begin
          ok = 1'b1;
          break;
        end
      end
      chk($sformatf("tbl%0d_found", i), 32'(ok), 32'(1));
      chk($sformatf("tbl%0d_code", i), 32'(bus.dig_code), 32'(vecs[i].code));
      chk($sformatf("tbl%0d_blank", i), 32'(bus.dec_blank), 32'(vecs[i].blank));
      chk($sformatf("tbl%0d_dpn", i), 32'(bus.dp_n), 32'(vecs[i].dpn));
    end

    // Asynchronous reset in the middle of a DRIVE phase.
    bus.blank_mask = '0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.dig_sel_n !== 4'hF) begin
        ok = 1'b1;
        break;
      end
    end
    chk("arst_in_drive", 32'(ok), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("pr_a0_sel", 32'(bus.dig_sel_n), 32'(4'hF));
    step();
    step();
    chk("pr_a2_sel", 32'(bus.dig_sel_n), 32'(4'hE));
    chk("pr_a2_code", 32'(bus.dig_code), 32'(0));
    wait_ft(40, n, ok);
    chk("pr_bnd_seen", 32'(ok), 32'(1));
    chk("pr_bnd_cyc", 32'(n), 32'(30));
    chk("pr_bnd_ud", 32'(bus.upd_done), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller for a multi-digit common-anode 7-segment display built around the team's single shared 4-bit hex-to-7-segment decoder. The block holds a double-buffered display value, sequences one nibble at a time onto the decoder inputs, and drives active-low digit selects. Between digits it inserts a blanking guard interval to suppress ghosting. It sits between the system register/value source and the decoder plus digit-driver pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2–8)
- REFRESH_DIV, 50000, clock cycles per digit slot (guard plus drive)
- GUARD_CYC, 16, blanked cycles at the start of each slot; must satisfy 1 ≤ GUARD_CYC < REFRESH_DIV

- clk, input, 1, system clock
- rst_n, input, 1, reset, asynchronous and active-low
- en, input, 1, scanning enable
- load, input, 1, one-cycle strobe; captures `value` and `dp_in` into the shadow buffer
- value, input, 4*NUM_DIGITS, display nibbles; digit i = value[4i+3:4i], digit 0 rightmost
- dp_in, input, NUM_DIGITS, decimal-point request per digit, active-high
- blank_mask, input, NUM_DIGITS, force digit i dark when bit i = 1; live input, not buffered
- dig_code, output, 4, nibble to decoder {D,C,B,A}
- dec_blank, output, 1, 1 = segment drivers forced off
- dig_sel_n, output, NUM_DIGITS, digit enables, active-low, at most one low
- dp_n, output, 1, decimal point, active-low
- scan_idx, output, clog2(NUM_DIGITS), current digit index
- frame_tick, output, 1, one-cycle pulse at frame boundary
- upd_done, output, 1, one-cycle pulse when shadow → active transfer occurs

## Operation
- All outputs are registered and change only on the rising edge of clk.
- Reset values:
  - dig_sel_n all ones; dig_code 0; dec_blank 1; dp_n 1; scan_idx 0; frame_tick 0; upd_done 0.
  - Shadow and active buffers 0; pending flag 0; slot counter 0; state IDLE.
- States:
  - IDLE: all digits off. When en=1, go to GUARD with idx 0.
  - GUARD: lasts GUARD_CYC cycles. dig_sel_n all ones and dec_blank 1. dig_code already shows active nibble[idx]. Then go to DRIVE.
  - DRIVE: lasts REFRESH_DIV−GUARD_CYC cycles.
    - dig_sel_n[idx]=0.
    - dec_blank = blank condition for idx.
    - dp_n = ~active_dp[idx], forced 1 when blanked.
    - At the end of DRIVE, idx increments and the block enters GUARD.
    - When idx = NUM_DIGITS−1 at the end of DRIVE, idx wraps to 0 (frame boundary).
- Frame boundary, same edge as the wrap:
  - frame_tick=1.
  - If pending=1: active ← shadow, pending ← 0, upd_done=1.
- load:
  - shadow ← {value, dp_in}, pending ← 1.
  - A new load overwrites any unapplied shadow.
  - load on the boundary cycle: the transfer uses the pre-edge shadow contents, the new data lands in shadow, and pending stays 1.
- en=0 in any state: the next edge goes to IDLE and clears idx and the counter. Buffers and pending are retained.
- Async reset mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge.
- Blank condition for digit i: blank_mask[i], OR'd with leading-zero blanking when that feature is compiled in.

## Timing
- Frame period = NUM_DIGITS × REFRESH_DIV cycles.
- First DRIVE starts GUARD_CYC+1 cycles after en rises; the +1 is the IDLE exit edge.
- load → visible on the pins: from 1 cycle after the next frame boundary up to one full frame plus 1.
- Slot counter width is clog2(REFRESH_DIV). It resets to 0 on every state change and never exceeds REFRESH_DIV−1.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking is enabled.
  - Digit i>0 is blanked when active nibbles i..NUM_DIGITS−1 are all zero.
  - Digit 0 is never auto-blanked.
  - The blanking decision is computed from the active buffer only.
- Not defined: only blank_mask blanks digits, and zeros display as "0".

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2.
- Reset, load value=16'h1234, then en=1:
  - Boundary reached → upd_done pulse.
  - Next frame: dig_code=4 with dig_sel_n=4'b1110 for 6 cycles; then 2 cycles all ones; then dig_code=3 with 4'b1101.
- Free run: frame_tick pulses exactly every 32 cycles, scan_idx sequence is 0,1,2,3,0.
- load 16'hABCD mid-frame while showing 16'h1234: pins keep showing 1234 until the boundary; upd_done coincides with frame_tick; the next frame shows D,C,B,A.
- en dropped during DRIVE of digit 2: the next edge gives dig_sel_n=4'hF, dec_blank=1, scan_idx=0; re-asserting en restarts at digit 0 after GUARD.
- value=16'h0050, dp_in=4'b0010, blank_mask=0:
  - With SEG7_LZB_EN: digits 3 and 2 have dec_blank=1, digit 1 shows 5 with dp_n=0.
  - Without SEG7_LZB_EN: digits 3 and 2 show 0.
- rst_n asserted asynchronously mid-DRIVE: all outputs are at reset values before the next clk edge; after release with en=1, the block behaves as at power-up.
